// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the five-stage MIPS pipeline.
// Optional LL/SC support is enabled by defining MEM_LLSC_EN.
module mem_access_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic [5:0]        mem_aluop,
    input  logic [DATA_W-1:0] mem_mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_ack,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              stall_req,
    output logic              misalign
`ifdef MEM_LLSC_EN
    ,
    input  logic              llbit_clr
`endif
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
`ifdef MEM_LLSC_EN
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e      state_q;
    logic [31:0] rdata_q;

    logic        is_load;
    logic        is_store;
    logic        ld_sign;
    size_e       acc_size;
    logic        is_mem;
    logic        misal;
    logic        sc_fail;
    logic        start;
    logic        in_idle;
    logic [1:0]  off;
    logic [3:0]  sel_d;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

`ifdef MEM_LLSC_EN
    logic        is_ll;
    logic        is_sc;
    logic        llbit_q;
`endif

    // Classify the op: direction, access size and extension mode
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        ld_sign  = 1'b0;
        acc_size = SZ_W;
`ifdef MEM_LLSC_EN
        is_ll    = 1'b0;
        is_sc    = 1'b0;
`endif
        unique case (mem_aluop)
            OP_LB:  begin is_load = 1'b1; ld_sign = 1'b1; acc_size = SZ_B; end
            OP_LH:  begin is_load = 1'b1; ld_sign = 1'b1; acc_size = SZ_H; end
            OP_LW:  begin is_load = 1'b1; end
            OP_LBU: begin is_load = 1'b1; acc_size = SZ_B; end
            OP_LHU: begin is_load = 1'b1; acc_size = SZ_H; end
            OP_SB:  begin is_store = 1'b1; acc_size = SZ_B; end
            OP_SH:  begin is_store = 1'b1; acc_size = SZ_H; end
            OP_SW:  begin is_store = 1'b1; end
`ifdef MEM_LLSC_EN
            OP_LL:  begin is_load = 1'b1; is_ll = 1'b1; end
            OP_SC:  begin is_store = 1'b1; is_sc = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign off     = mem_mem_addr[1:0];
    assign is_mem  = is_load | is_store;
    assign in_idle = (state_q == IDLE);
    assign misal   = is_mem &&
                     ((acc_size == SZ_H && off[0]) ||
                      (acc_size == SZ_W && off != 2'd0));
`ifdef MEM_LLSC_EN
    // A failed SC resolves in its first cycle without touching the bus
    assign sc_fail = is_sc & ~llbit_q & in_idle;
`else
    assign sc_fail = 1'b0;
`endif
    assign start     = in_idle & is_mem & ~misal & ~sc_fail;
    assign stall_req = ~rst & (start | (state_q == BUSY));
    assign misalign  = ~rst & in_idle & misal;

    // Big-endian byte enables and lane-replicated store data
    always_comb begin
        sel_d   = 4'b1111;
        st_data = mem_reg2;
        unique case (acc_size)
            SZ_B: begin
                sel_d   = 4'b1000 >> off;
                st_data = {4{mem_reg2[7:0]}};
            end
            SZ_H: begin
                sel_d   = off[1] ? 4'b0011 : 4'b1100;
                st_data = {2{mem_reg2[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the latched read word and extend it
    always_comb begin
        ld_byte = rdata_q[31:24];
        unique case (off)
            2'd0: ld_byte = rdata_q[31:24];
            2'd1: ld_byte = rdata_q[23:16];
            2'd2: ld_byte = rdata_q[15:8];
            2'd3: ld_byte = rdata_q[7:0];
        endcase
        ld_half = off[1] ? rdata_q[15:0] : rdata_q[31:16];
        ld_ext  = rdata_q;
        unique case (acc_size)
            SZ_B:    ld_ext = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_ext = {{16{ld_sign & ld_half[15]}}, ld_half};
            default: ld_ext = rdata_q;
        endcase
    end

    // Results toward MEM/WB; loads only become valid in DONE
    always_comb begin
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        wb_whilo = mem_whilo;
        wb_hi    = mem_hi;
        wb_lo    = mem_lo;
        if (misalign) begin
            wb_wreg = 1'b0;
        end else if (sc_fail) begin
            wb_wdata = '0;
        end else if (state_q == DONE && is_mem) begin
            if (is_load) wb_wdata = ld_ext;
`ifdef MEM_LLSC_EN
            if (is_sc) wb_wdata = 32'd1;
`endif
        end
    end

    // Bus handshake FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_sel   <= '0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
`ifdef MEM_LLSC_EN
            llbit_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_sel   <= sel_d;
                        dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
                        dbus_wdata <= st_data;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        rdata_q  <= dbus_rdata;
                        state_q  <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
`ifdef MEM_LLSC_EN
            if (llbit_clr) begin
                llbit_q <= 1'b0;
            end else if (state_q == BUSY && dbus_ack) begin
                if (is_ll) llbit_q <= 1'b1;
                else if (is_sc) llbit_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized checks of mem_access_stage against
// a behavioural model of the load/store rules.
module tb_mem_access_stage;

    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] LL  = 6'h30;
    localparam logic [5:0] SC  = 6'h38;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [5:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        stall_req;
    logic        misalign;
`ifdef MEM_LLSC_EN
    logic        llbit_clr;
`endif

    int errors = 0;
    int checks = 0;
    bit ll_model;

    logic [3:0]  obs_sel;
    logic [31:0] obs_bwd;
    logic [31:0] obs_wb;
    bit          obs_we;
    bit          obs_req;
    bit          obs_mis;
    bit          obs_wreg;
    int          obs_stall;

    mem_access_stage #(.DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .mem_wd(mem_wd),
        .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo),
        .mem_hi(mem_hi),
        .mem_lo(mem_lo),
        .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2),
        .wb_wd(wb_wd),
        .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo),
        .wb_hi(wb_hi),
        .wb_lo(wb_lo),
        .dbus_req(dbus_req),
        .dbus_we(dbus_we),
        .dbus_sel(dbus_sel),
        .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata),
        .stall_req(stall_req),
        .misalign(misalign)
`ifdef MEM_LLSC_EN
        ,
        .llbit_clr(llbit_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_mem_op(input logic [5:0] op);
`ifdef MEM_LLSC_EN
        return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW, LL, SC};
`else
        return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
`endif
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [10] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, LL, SC};
`ifdef MEM_LLSC_EN
        return tbl[$urandom_range(0, 9)];
`else
        return tbl[$urandom_range(0, 7)];
`endif
    endfunction

    task automatic rand_side();
        mem_wd    = 5'($urandom);
        mem_wreg  = 1'($urandom);
        mem_wdata = $urandom;
        mem_whilo = 1'($urandom);
        mem_hi    = $urandom;
        mem_lo    = $urandom;
    endtask

    // Run one load/store through the stage and compare with the model
    task automatic mem_op(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] r2, input logic [31:0] rd,
                          input int nb);
        int s, o;
        bit ld, sg, st, ll, sc, mis, bus;
        logic [3:0]  esel;
        logic [31:0] ewd, ewb, lo8, lo16;
        bit          ewreg;
        longint      v;
        s = 0; ld = 0; sg = 0; st = 0; ll = 0; sc = 0;
        case (op)
            LB:  begin s = 1; ld = 1; sg = 1; end
            LH:  begin s = 2; ld = 1; sg = 1; end
            LW:  begin s = 4; ld = 1; end
            LBU: begin s = 1; ld = 1; end
            LHU: begin s = 2; ld = 1; end
            SB:  begin s = 1; st = 1; end
            SH:  begin s = 2; st = 1; end
            SW:  begin s = 4; st = 1; end
`ifdef MEM_LLSC_EN
            LL:  begin s = 4; ld = 1; ll = 1; end
            SC:  begin s = 4; st = 1; sc = 1; end
`endif
            default: ;
        endcase
        rand_side();
        mem_aluop    = op;
        mem_mem_addr = a;
        mem_reg2     = r2;
        o   = int'(a[1:0]);
        mis = (s != 0) && (o % s != 0);
        bus = (s != 0) && !mis && !(sc && !ll_model);
        esel = 4'b0000;
        ewb  = mem_wdata;
        ewreg = mem_wreg;
        lo8  = {24'd0, r2[7:0]};
        lo16 = {16'd0, r2[15:0]};
        ewd  = (s == 1) ? lo8 * 32'h0101_0101 :
               (s == 2) ? lo16 * 32'h0001_0001 : r2;
        if (bus) begin
            esel = 4'(((1 << s) - 1) << (4 - o - s));
            if (ld) begin
                v = (longint'(rd) >> (8 * (4 - o - s))) &
                    ((longint'(1) << (8 * s)) - 1);
                if (sg && v[8 * s - 1]) v = v - (longint'(1) << (8 * s));
                ewb = v[31:0];
            end
            if (sc) ewb = 32'd1;
        end else if (mis) begin
            ewreg = 1'b0;
        end else if (s != 0) begin
            ewb = 32'd0;
        end
        obs_req = 0; obs_stall = 0; obs_we = 0; obs_sel = 0; obs_bwd = 0;
        if (!bus) begin
            dbus_ack   = 1'($urandom);
            dbus_rdata = $urandom;
            @(negedge clk);
            obs_mis = misalign; obs_req = dbus_req; obs_wb = wb_wdata;
            obs_wreg = wb_wreg; obs_stall = int'(stall_req);
            checks++; if (misalign !== mis) begin errors++;
                $display("FAIL nobus_misalign op=%h: got %b expected %b", op, misalign, mis); end
            checks++; if (stall_req !== 1'b0) begin errors++;
                $display("FAIL nobus_stall op=%h: got %b expected 0", op, stall_req); end
            checks++; if (dbus_req !== 1'b0) begin errors++;
                $display("FAIL nobus_req op=%h: got %b expected 0", op, dbus_req); end
            checks++; if (wb_wdata !== ewb) begin errors++;
                $display("FAIL nobus_wdata op=%h: got %h expected %h", op, wb_wdata, ewb); end
            checks++; if (wb_wreg !== ewreg) begin errors++;
                $display("FAIL nobus_wreg op=%h: got %b expected %b", op, wb_wreg, ewreg); end
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c <= nb + 1; c++) begin
                if (c == nb) dbus_ack = 1'b1;
                else if (c == 0 || c == nb + 1) dbus_ack = 1'($urandom);
                else dbus_ack = 1'b0;
                dbus_rdata = (c == nb) ? rd : $urandom;
                @(negedge clk);
                if (stall_req === 1'b1) obs_stall++;
                if (dbus_req === 1'b1) obs_req = 1;
                checks++; if (stall_req !== (c <= nb)) begin errors++;
                    $display("FAIL stall op=%h cyc=%0d: got %b expected %b", op, c, stall_req, c <= nb); end
                checks++; if (dbus_req !== (c >= 1 && c <= nb)) begin errors++;
                    $display("FAIL req op=%h cyc=%0d: got %b", op, c, dbus_req); end
                checks++; if (misalign !== 1'b0) begin errors++;
                    $display("FAIL misalign op=%h cyc=%0d: got %b expected 0", op, c, misalign); end
                if (c >= 1 && c <= nb) begin
                    obs_sel = dbus_sel; obs_we = dbus_we; obs_bwd = dbus_wdata;
                    checks++; if (dbus_we !== st) begin errors++;
                        $display("FAIL we op=%h: got %b expected %b", op, dbus_we, st); end
                    checks++; if (dbus_sel !== esel) begin errors++;
                        $display("FAIL sel op=%h a=%h: got %b expected %b", op, a, dbus_sel, esel); end
                    checks++; if (dbus_addr !== {a[31:2], 2'b00}) begin errors++;
                        $display("FAIL addr op=%h: got %h expected %h", op, dbus_addr, {a[31:2], 2'b00}); end
                    if (st) begin
                        checks++; if (dbus_wdata !== ewd) begin errors++;
                            $display("FAIL bus_wdata op=%h: got %h expected %h", op, dbus_wdata, ewd); end
                    end
                end
                if (c == nb + 1) begin
                    obs_wb = wb_wdata; obs_wreg = wb_wreg;
                    checks++; if (wb_wdata !== ewb) begin errors++;
                        $display("FAIL wb_wdata op=%h a=%h rd=%h: got %h expected %h", op, a, rd, wb_wdata, ewb); end
                    checks++; if (wb_wreg !== ewreg) begin errors++;
                        $display("FAIL wb_wreg op=%h: got %b expected %b", op, wb_wreg, ewreg); end
                    checks++; if (wb_hi !== mem_hi) begin errors++;
                        $display("FAIL wb_hi op=%h: got %h expected %h", op, wb_hi, mem_hi); end
                end
                @(posedge clk); #1;
            end
            dbus_ack = 1'b0;
`ifdef MEM_LLSC_EN
            if (ll) ll_model = !llbit_clr;
`endif
            if (sc) ll_model = 0;
        end
    endtask

    task automatic nop_cycle();
        mem_aluop = NOP;
        rand_side();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dbus_ack = 1'b1;
        dbus_rdata = $urandom;
        mem_aluop = NOP;
        mem_mem_addr = $urandom;
        mem_reg2 = $urandom;
        rand_side();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", dbus_req); end
        checks++; if (dbus_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", dbus_we); end
        checks++; if (dbus_sel !== 4'h0) begin errors++; $display("FAIL rst_sel: got %h expected 0", dbus_sel); end
        checks++; if (dbus_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", dbus_addr); end
        checks++; if (dbus_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", dbus_wdata); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_req); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign); end
        checks++; if (wb_wdata !== mem_wdata) begin errors++;
            $display("FAIL rst_wb_wdata: got %h expected %h", wb_wdata, mem_wdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        dbus_ack = 1'b0;
        ll_model = 0;
    endtask

    task automatic test_passthrough();
        logic [5:0] op;
        for (int i = 0; i < 10; i++) begin
            op = 6'($urandom);
            if (i == 0 || is_mem_op(op)) op = NOP;
            mem_aluop = op;
            mem_mem_addr = $urandom;
            mem_reg2 = $urandom;
            rand_side();
            if (i == 0) mem_wdata = 32'h1234;
            dbus_ack = 1'($urandom);
            @(negedge clk);
            checks++; if ({wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo} !==
                          {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo}) begin errors++;
                $display("FAIL pass_wb op=%h: got wdata %h expected %h", op, wb_wdata, mem_wdata); end
            checks++; if ({stall_req, dbus_req, misalign} !== 3'b000) begin errors++;
                $display("FAIL pass_ctrl op=%h: got %b expected 000", op, {stall_req, dbus_req, misalign}); end
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0;
    endtask

    task automatic test_lb();
        mem_op(LB, 32'h101, $urandom, 32'h1180_2233, 1);
        checks++; if (obs_sel !== 4'b0100) begin errors++; $display("FAIL lb_sel: got %b expected 0100", obs_sel); end
        checks++; if (obs_stall !== 2) begin errors++; $display("FAIL lb_stall_cycles: got %0d expected 2", obs_stall); end
        checks++; if (obs_wb !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata: got %h expected ffffff80", obs_wb); end
        nop_cycle();
    endtask

    task automatic test_sh();
        mem_op(SH, 32'h202, 32'hAAAA_BEEF, $urandom, 3);
        checks++; if (obs_sel !== 4'b0011) begin errors++; $display("FAIL sh_sel: got %b expected 0011", obs_sel); end
        checks++; if (obs_bwd !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h expected beefbeef", obs_bwd); end
        checks++; if (obs_stall !== 4) begin errors++; $display("FAIL sh_stall_cycles: got %0d expected 4", obs_stall); end
        nop_cycle();
    endtask

    task automatic test_misalign();
        mem_op(LW, 32'h6, $urandom, $urandom, 1);
        checks++; if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", obs_mis); end
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", obs_req); end
        checks++; if (obs_wreg !== 1'b0) begin errors++; $display("FAIL mis_wreg: got %b expected 0", obs_wreg); end
        mem_aluop = NOP;
        @(negedge clk);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", misalign); end
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL mis_req_after: got %b expected 0", dbus_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        mem_aluop = LW;
        mem_mem_addr = 32'h40;
        rand_side();
        dbus_ack = 1'b0;
        @(negedge clk);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rb_stall_idle: got %b expected 1", stall_req); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL rb_req_busy: got %b expected 1", dbus_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_aluop = NOP;
        ll_model = 0;
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rb_req: got %b expected 0", dbus_req); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rb_stall: got %b expected 0", stall_req); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rb_req_later: got %b expected 0", dbus_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        mem_op(LW, 32'h300, $urandom, $urandom, 1);
        mem_op(SW, 32'h304, $urandom, $urandom, 2);
        mem_op(LBU, 32'h307, $urandom, $urandom, 1);
        mem_op(LHU, 32'h30A, $urandom, $urandom, 1);
        nop_cycle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            mem_op(pick_op(), a, $urandom, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) nop_cycle();
        end
        nop_cycle();
    endtask

`ifdef MEM_LLSC_EN
    task automatic test_llsc();
        llbit_clr = 1'b0;
        mem_op(LL, 32'h100, $urandom, 32'hDEAD_BEEF, 1);
        mem_op(SC, 32'h100, 32'd5, $urandom, 2);
        checks++; if (obs_req !== 1'b1 || obs_we !== 1'b1) begin errors++;
            $display("FAIL sc_ok_bus: got req=%b we=%b expected 1 1", obs_req, obs_we); end
        checks++; if (obs_bwd !== 32'd5) begin errors++; $display("FAIL sc_ok_data: got %h expected 5", obs_bwd); end
        checks++; if (obs_wb !== 32'd1) begin errors++; $display("FAIL sc_ok_wb: got %h expected 1", obs_wb); end
        mem_op(SC, 32'h104, 32'd7, $urandom, 1);
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL sc_fail_req: got %b expected 0", obs_req); end
        checks++; if (obs_wb !== 32'd0) begin errors++; $display("FAIL sc_fail_wb: got %h expected 0", obs_wb); end
        mem_op(LL, 32'h200, $urandom, $urandom, 1);
        llbit_clr = 1'b1;
        nop_cycle();
        llbit_clr = 1'b0;
        ll_model = 0;
        mem_op(SC, 32'h200, 32'd9, $urandom, 1);
        checks++; if (obs_wb !== 32'd0) begin errors++; $display("FAIL sc_after_clr: got %h expected 0", obs_wb); end
        llbit_clr = 1'b1;
        mem_op(LL, 32'h208, $urandom, $urandom, 1);
        llbit_clr = 1'b0;
        mem_op(SC, 32'h208, 32'd3, $urandom, 1);
        checks++; if (obs_wb !== 32'd0) begin errors++; $display("FAIL sc_clr_wins: got %h expected 0", obs_wb); end
        nop_cycle();
    endtask
`else
    task automatic test_llsc_passthrough();
        logic [5:0] ops [2] = '{LL, SC};
        for (int i = 0; i < 2; i++) begin
            mem_aluop = ops[i];
            mem_mem_addr = 32'h101;
            mem_reg2 = $urandom;
            rand_side();
            @(negedge clk);
            checks++; if (wb_wdata !== mem_wdata || wb_wreg !== mem_wreg) begin errors++;
                $display("FAIL llsc_pass_wb op=%h: got %h expected %h", ops[i], wb_wdata, mem_wdata); end
            checks++; if ({stall_req, dbus_req, misalign} !== 3'b000) begin errors++;
                $display("FAIL llsc_pass_ctrl op=%h: got %b expected 000", ops[i], {stall_req, dbus_req, misalign}); end
            @(posedge clk); #1;
        end
        nop_cycle();
    endtask
`endif

    initial begin
        ll_model = 0;
`ifdef MEM_LLSC_EN
        llbit_clr = 1'b0;
`endif
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_misalign();
        test_reset_busy();
        test_back_to_back();
`ifdef MEM_LLSC_EN
        test_llsc();
`else
        test_llsc_passthrough();
`endif
        test_random();
        test_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
